// File: rtl/lc3_pkg.sv
// Shared constants for the LC-3 control sequencer.
// Covers state-chart numbers, opcodes and the set of memory-access states.
package lc3_pkg;

    localparam logic [5:0] S_ADD       = 6'd1;
    localparam logic [5:0] S_LD        = 6'd2;
    localparam logic [5:0] S_ST        = 6'd3;
    localparam logic [5:0] S_AND       = 6'd5;
    localparam logic [5:0] S_LDR       = 6'd6;
    localparam logic [5:0] S_STR       = 6'd7;
    localparam logic [5:0] S_NOT       = 6'd9;
    localparam logic [5:0] S_LDI       = 6'd10;
    localparam logic [5:0] S_STI       = 6'd11;
    localparam logic [5:0] S_JMP       = 6'd12;
    localparam logic [5:0] S_LEA       = 6'd14;
    localparam logic [5:0] S_TRAP      = 6'd15;
    localparam logic [5:0] S_WRITE     = 6'd16;
    localparam logic [5:0] S_FETCH     = 6'd18;
    localparam logic [5:0] S_JSRR      = 6'd20;
    localparam logic [5:0] S_JSR       = 6'd21;
    localparam logic [5:0] S_BR_TAKEN  = 6'd22;
    localparam logic [5:0] S_ST_MAR    = 6'd23;
    localparam logic [5:0] S_LDI_RD    = 6'd24;
    localparam logic [5:0] S_RD        = 6'd25;
    localparam logic [5:0] S_LDI_MAR   = 6'd26;
    localparam logic [5:0] S_LD_DONE   = 6'd27;
    localparam logic [5:0] S_TRAP_RD   = 6'd28;
    localparam logic [5:0] S_STI_RD    = 6'd29;
    localparam logic [5:0] S_TRAP_PC   = 6'd30;
    localparam logic [5:0] S_STI_MAR   = 6'd31;
    localparam logic [5:0] S_DECODE    = 6'd32;
    localparam logic [5:0] S_FETCH_RD  = 6'd33;
    localparam logic [5:0] S_FETCH_IR  = 6'd35;
    localparam logic [5:0] S_RTI_RD    = 6'd36;
    localparam logic [5:0] S_RTI_PC    = 6'd38;
    localparam logic [5:0] S_PRIV_EXC  = 6'd44;
    localparam logic [5:0] S_ILL_EXC   = 6'd45;
    localparam logic [5:0] S_INT       = 6'd49;
    localparam logic [5:0] S_FAULT     = 6'd63;

    localparam logic [3:0] OP_BR   = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_LD   = 4'd2;
    localparam logic [3:0] OP_ST   = 4'd3;
    localparam logic [3:0] OP_JSR  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_LDR  = 4'd6;
    localparam logic [3:0] OP_STR  = 4'd7;
    localparam logic [3:0] OP_RTI  = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;
    localparam logic [3:0] OP_LDI  = 4'd10;
    localparam logic [3:0] OP_STI  = 4'd11;
    localparam logic [3:0] OP_JMP  = 4'd12;
    localparam logic [3:0] OP_RES  = 4'd13;
    localparam logic [3:0] OP_LEA  = 4'd14;
    localparam logic [3:0] OP_TRAP = 4'd15;

    localparam int unsigned NUM_MEM_STATES = 7;
    localparam logic [5:0] MEM_STATES [NUM_MEM_STATES] = '{
        S_FETCH_RD, S_RD, S_TRAP_RD, S_LDI_RD, S_STI_RD, S_RTI_RD, S_WRITE
    };

    function automatic logic is_mem_state(input logic [5:0] s);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_MEM_STATES; i++) begin
            if (MEM_STATES[i] == s) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/lc3_mem_wait.sv
// Memory wait counter: counts held cycles in a memory state and flags a timeout
// when the access has not completed within TIMEOUT cycles (0 disables the check).
module lc3_mem_wait #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_mem_state_i,
    input  logic mem_ready_i,
    output logic advance_o,
    output logic timeout_o
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value seen on the last permitted wait cycle.
    localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold;

    always_comb begin
        advance_o = in_mem_state_i && mem_ready_i;
        hold      = in_mem_state_i && !mem_ready_i;
        timeout_o = hold && (TIMEOUT != 0) && (cnt_q == LIMIT);
        cnt_d     = '0;
        if (hold && !timeout_o) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 one-hot control sequencer with variable-latency memory handshakes,
// interrupt entry, exception states and a sticky memory-timeout fault.
module lc3_ctrl_fsm
    import lc3_pkg::*;
#(
    parameter int unsigned NUM_STATES = 64,
    parameter int unsigned TIMEOUT    = 16,
    parameter bit          INT_EN     = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [3:0]            Opcode,
    input  logic                  IR11,
    input  logic                  BEN,
    input  logic                  PSR15,
    input  logic                  MemReady,
    input  logic                  IntReq,
    output logic [NUM_STATES-1:0] StateOH,
    output logic [5:0]            StateNum,
    output logic                  MemEn,
    output logic                  MemWe,
    output logic                  LdMAR,
    output logic                  LdMDR,
    output logic                  LdIR,
    output logic                  LdPC,
    output logic                  LdReg,
    output logic                  LdCC,
    output logic                  LdBEN,
    output logic                  IntAck,
    output logic                  ExcAck,
    output logic                  Fault
);

    localparam logic [NUM_STATES-1:0] FETCH_OH = {{(NUM_STATES-1){1'b0}}, 1'b1} << S_FETCH;

    logic [NUM_STATES-1:0] state_q, state_d;
    logic [5:0]            state_num, next_num, idx;
    logic                  found, in_mem, advance, timeout;

    // State register
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= FETCH_OH;
        end else begin
            state_q <= state_d;
        end
    end

    // Zero-hot, multi-hot or a bit above 63 all read back as FAULT.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 64; i++) begin
            if (state_q[i]) begin
                idx   = 6'(i);
                found = 1'b1;
            end
        end
        state_num = ($onehot(state_q) && found) ? idx : S_FAULT;
    end

    assign in_mem = is_mem_state(state_num);

    lc3_mem_wait #(
        .TIMEOUT(TIMEOUT)
    ) u_mem_wait (
        .clk_i         (Clock),
        .rst_ni        (Reset),
        .in_mem_state_i(in_mem),
        .mem_ready_i   (MemReady),
        .advance_o     (advance),
        .timeout_o     (timeout)
    );

    // Next-state logic
    always_comb begin
        next_num = S_FAULT;
        case (state_num)
            S_FETCH:    next_num = (INT_EN && IntReq) ? S_INT : S_FETCH_RD;
            S_FETCH_RD: next_num = S_FETCH_IR;
            S_FETCH_IR: next_num = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_BR:                  next_num = BEN ? S_BR_TAKEN : S_FETCH;
                    OP_JSR:                 next_num = IR11 ? S_JSR : S_JSRR;
                    OP_RTI:                 next_num = PSR15 ? S_PRIV_EXC : S_RTI_RD;
                    OP_RES:                 next_num = S_ILL_EXC;
                    default:                next_num = {2'b00, Opcode};
                endcase
            end
            S_ADD, S_AND, S_NOT, S_LEA, S_JMP, S_JSR, S_JSRR, S_BR_TAKEN, S_LD_DONE,
            S_TRAP_PC, S_RTI_PC, S_PRIV_EXC, S_ILL_EXC, S_INT, S_WRITE:
                        next_num = S_FETCH;
            S_LD, S_LDR, S_LDI_MAR: next_num = S_RD;
            S_RD:       next_num = S_LD_DONE;
            S_LDI:      next_num = S_LDI_RD;
            S_LDI_RD:   next_num = S_LDI_MAR;
            S_ST, S_STR, S_STI_MAR: next_num = S_ST_MAR;
            S_ST_MAR:   next_num = S_WRITE;
            S_STI:      next_num = S_STI_RD;
            S_STI_RD:   next_num = S_STI_MAR;
            S_TRAP:     next_num = S_TRAP_RD;
            S_TRAP_RD:  next_num = S_TRAP_PC;
            S_RTI_RD:   next_num = S_RTI_PC;
            default:    next_num = S_FAULT;
        endcase
        if (in_mem && !advance) begin
            next_num = timeout ? S_FAULT : state_num;
        end
        state_d           = '0;
        state_d[next_num] = 1'b1;
    end

    // Moore outputs
    always_comb begin
        MemEn  = in_mem;
        MemWe  = (state_num == S_WRITE);
        LdMDR  = in_mem && (state_num != S_WRITE);
        LdMAR  = 1'b0;
        LdIR   = 1'b0;
        LdPC   = 1'b0;
        LdReg  = 1'b0;
        LdCC   = 1'b0;
        LdBEN  = 1'b0;
        IntAck = 1'b0;
        ExcAck = 1'b0;
        Fault  = 1'b0;
        case (state_num)
            S_FETCH:    begin LdMAR = 1'b1; LdPC = 1'b1; end
            S_FETCH_IR: LdIR = 1'b1;
            S_DECODE:   LdBEN = 1'b1;
            S_INT:      begin IntAck = 1'b1; LdPC = 1'b1; end
            S_ADD, S_AND, S_NOT, S_LEA, S_LD_DONE: begin LdReg = 1'b1; LdCC = 1'b1; end
            S_JMP, S_BR_TAKEN, S_TRAP_PC, S_RTI_PC: LdPC = 1'b1;
            S_JSR, S_JSRR: begin LdReg = 1'b1; LdPC = 1'b1; end
            S_LD, S_LDR, S_LDI, S_LDI_MAR, S_ST, S_STR, S_STI, S_STI_MAR, S_ST_MAR:
                        LdMAR = 1'b1;
            S_TRAP_RD:  begin LdReg = 1'b1; LdMAR = 1'b1; end
            S_PRIV_EXC, S_ILL_EXC: begin ExcAck = 1'b1; LdPC = 1'b1; end
            S_FAULT:    Fault = 1'b1;
            default:    ;
        endcase
    end

    assign StateOH  = state_q;
    assign StateNum = state_num;

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Randomized bench for lc3_ctrl_fsm: an instruction-level path model predicts
// the state walk and per-state strobes; directed runs cover reset and timeout.
module tb_lc3_ctrl_fsm;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [3:0]  Opcode;
    logic        IR11, BEN, PSR15, MemReady, IntReq;
    logic [63:0] StateOH;
    logic [5:0]  StateNum;
    logic        MemEn, MemWe, LdMAR, LdMDR, LdIR, LdPC, LdReg, LdCC, LdBEN;
    logic        IntAck, ExcAck, Fault;

    int n_checks = 0;
    int n_errors = 0;
    int lat_fixed = -1;
    int path[$];
    bit done = 1'b0;

    lc3_ctrl_fsm #(
        .NUM_STATES(64),
        .TIMEOUT   (16),
        .INT_EN    (1'b1)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Opcode  (Opcode),
        .IR11    (IR11),
        .BEN     (BEN),
        .PSR15   (PSR15),
        .MemReady(MemReady),
        .IntReq  (IntReq),
        .StateOH (StateOH),
        .StateNum(StateNum),
        .MemEn   (MemEn),
        .MemWe   (MemWe),
        .LdMAR   (LdMAR),
        .LdMDR   (LdMDR),
        .LdIR    (LdIR),
        .LdPC    (LdPC),
        .LdReg   (LdReg),
        .LdCC    (LdCC),
        .LdBEN   (LdBEN),
        .IntAck  (IntAck),
        .ExcAck  (ExcAck),
        .Fault   (Fault)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_mem(input int s);
        int mem_list[7] = '{33, 25, 28, 24, 29, 36, 16};
        for (int i = 0; i < 7; i++) if (mem_list[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    // Bit order: MemEn MemWe LdMAR LdMDR LdIR LdPC LdReg LdCC LdBEN IntAck ExcAck Fault
    function automatic logic [11:0] exp_strobes(input int s);
        logic [11:0] v;
        v = '0;
        if (is_mem(s)) begin
            v[11] = 1'b1;
            if (s == 16) v[10] = 1'b1; else v[8] = 1'b1;
        end
        case (s)
            18:                             begin v[9] = 1'b1; v[6] = 1'b1; end
            35:                             v[7] = 1'b1;
            32:                             v[3] = 1'b1;
            49:                             begin v[2] = 1'b1; v[6] = 1'b1; end
            1, 5, 9, 14, 27:                begin v[5] = 1'b1; v[4] = 1'b1; end
            12, 22, 30, 38:                 v[6] = 1'b1;
            20, 21:                         begin v[5] = 1'b1; v[6] = 1'b1; end
            2, 6, 10, 26, 3, 7, 11, 31, 23: v[9] = 1'b1;
            28:                             begin v[5] = 1'b1; v[9] = 1'b1; end
            44, 45:                         begin v[1] = 1'b1; v[6] = 1'b1; end
            63:                             v[0] = 1'b1;
            default:                        ;
        endcase
        return v;
    endfunction

    function automatic logic [11:0] act_strobes();
        return {MemEn, MemWe, LdMAR, LdMDR, LdIR, LdPC, LdReg, LdCC, LdBEN, IntAck, ExcAck,
                Fault};
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic observe(input int s);
        logic [63:0] oh;
        oh = 64'd1 << s;
        check($sformatf("state_num(exp %0d)", s), 64'(StateNum), 64'(s));
        check($sformatf("state_oh(exp %0d)", s), StateOH, oh);
        check($sformatf("strobes@%0d", s), 64'(act_strobes()), 64'(exp_strobes(s)));
    endtask

    // Spend the expected number of cycles in state s; memory states wait a random latency.
    task automatic visit(input int s, input bit ireq);
        int lat;
        IntReq = ireq;
        if (is_mem(s)) begin
            lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 5));
            for (int k = 0; k <= lat; k++) begin
                observe(s);
                MemReady = (k == lat);
                step();
            end
        end else begin
            observe(s);
            MemReady = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    task automatic build_path(input int op, input bit ben, input bit ir11, input bit psr);
        path.delete();
        case (op)
            0:                  if (ben) path.push_back(22);
            1, 5, 9, 12, 14:    path.push_back(op);
            4:                  path.push_back(ir11 ? 21 : 20);
            2, 6:               begin path.push_back(op); path.push_back(25); path.push_back(27); end
            10: begin
                path.push_back(10); path.push_back(24); path.push_back(26);
                path.push_back(25); path.push_back(27);
            end
            3, 7:               begin path.push_back(op); path.push_back(23); path.push_back(16); end
            11: begin
                path.push_back(11); path.push_back(29); path.push_back(31);
                path.push_back(23); path.push_back(16);
            end
            15:                 begin path.push_back(15); path.push_back(28); path.push_back(30); end
            8: begin
                if (psr) path.push_back(44);
                else begin path.push_back(36); path.push_back(38); end
            end
            default:            path.push_back(45);
        endcase
    endtask

    task automatic run_instr(input int op, input bit ben, input bit ir11, input bit psr,
                             input int n_irq);
        int p[$];
        Opcode = 4'(op);
        BEN    = ben;
        IR11   = ir11;
        PSR15  = psr;
        for (int i = 0; i < n_irq; i++) begin
            visit(18, 1'b1);
            visit(49, 1'($urandom_range(0, 1)));
        end
        visit(18, 1'b0);
        visit(33, 1'($urandom_range(0, 1)));
        visit(35, 1'($urandom_range(0, 1)));
        visit(32, 1'($urandom_range(0, 1)));
        build_path(op, ben, ir11, psr);
        p = path;
        foreach (p[i]) visit(p[i], 1'($urandom_range(0, 1)));
    endtask

    task automatic finish_run();
        if (!done) begin
            done = 1'b1;
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $finish;
        end
    endtask

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: run did not complete in time");
        finish_run();
    end

    initial begin
        Reset = 1'b0; Opcode = '0; IR11 = 1'b0; BEN = 1'b0; PSR15 = 1'b0;
        MemReady = 1'b0; IntReq = 1'b0;
        step();
        step();
        Reset = 1'b1;
        observe(18);
        check("fault_after_reset", 64'(Fault), 64'd0);

        lat_fixed = 0;
        run_instr(1, 1'b0, 1'b0, 1'b0, 0);
        lat_fixed = 3;
        run_instr(10, 1'b0, 1'b0, 1'b0, 0);
        lat_fixed = 0;
        run_instr(13, 1'b0, 1'b0, 1'b0, 0);
        run_instr(8, 1'b0, 1'b0, 1'b1, 0);
        run_instr(1, 1'b0, 1'b0, 1'b0, 1);
        lat_fixed = -1;
        for (int n = 0; n < 300; n++) begin
            run_instr(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        // Reset in the middle of a held fetch read.
        IntReq = 1'b0;
        MemReady = 1'b0;
        step();
        for (int k = 0; k < 6; k++) begin
            observe(33);
            step();
        end
        Reset = 1'b0;
        step();
        step();
        Reset = 1'b1;
        observe(18);
        check("fault_after_mid_reset", 64'(Fault), 64'd0);

        // Full timeout: a stale counter would fault early.
        step();
        for (int k = 0; k < 16; k++) begin
            observe(33);
            step();
        end
        for (int k = 0; k < 11; k++) begin
            observe(63);
            check("fault_sticky", 64'(Fault), 64'd1);
            MemReady = 1'($urandom_range(0, 1));
            IntReq   = 1'($urandom_range(0, 1));
            step();
        end

        Reset = 1'b0;
        IntReq = 1'b0;
        MemReady = 1'b0;
        step();
        step();
        Reset = 1'b1;
        observe(18);

        // MemReady arriving on the last permitted wait cycle wins over the timeout.
        step();
        for (int k = 0; k < 16; k++) begin
            observe(33);
            MemReady = (k == 15);
            step();
        end
        observe(35);
        check("fault_ready_at_limit", 64'(Fault), 64'd0);

        finish_run();
    end

endmodule
